// File: rtl/al_timekeeper_pkg.sv
// al_timekeeper_pkg
//   Shared definitions for the time-of-day / alarm core.
//   - alarm_state_e : alarm state machine encodings
//   - BCD digit limits used by the hh:mm incrementer
//   - 12-hour display conversion helpers (hour_to_12, hour_is_pm)
package al_timekeeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RINGING  = 2'd1,
    ST_SNOOZING = 2'd2
  } alarm_state_e;

  // BCD digit limits
  localparam logic [3:0] LS_DIGIT_MAX    = 4'd9;  // any least-significant digit
  localparam logic [3:0] MS_MIN_MAX      = 4'd5;  // tens of minutes
  localparam logic [3:0] MS_HOUR_MAX     = 4'd2;  // tens of hours
  localparam logic [3:0] LS_HOUR_MAX_TOP = 4'd3;  // units of hours when tens is 2

  // 12-hour conversion constants (BCD hours)
  localparam logic [7:0] HOUR_MIDNIGHT = 8'h00;
  localparam logic [7:0] HOUR_NOON     = 8'h12;
  localparam logic [7:0] HOUR_20       = 8'h20;
  localparam logic [7:0] HOUR_21       = 8'h21;

  // 24-hour BCD hour -> 12-hour BCD hour.
  // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11.
  // Subtracting 8'h12 is a valid BCD subtraction except for 20 and 21,
  // where the units digit would need a borrow; those two are tabled.
  function automatic logic [7:0] hour_to_12(input logic [7:0] h24);
    logic [7:0] r;
    if (h24 == HOUR_MIDNIGHT) begin
      r = HOUR_NOON;
    end else if (h24 <= HOUR_NOON) begin
      r = h24;
    end else if (h24 == HOUR_20) begin
      r = 8'h08;
    end else if (h24 == HOUR_21) begin
      r = 8'h09;
    end else begin
      r = h24 - HOUR_NOON;
    end
    return r;
  endfunction

  // BCD ordering matches numeric ordering, so a plain compare works.
  function automatic logic hour_is_pm(input logic [7:0] h24);
    return (h24 >= HOUR_NOON);
  endfunction

endpackage

// File: rtl/al_timekeeper_bcd_hhmm_inc.sv
// al_timekeeper_bcd_hhmm_inc
//   Combinational increment of a 24-hour BCD hh:mm value.
//   Ports:
//     hhmm      in  16  {ms_hour, ls_hour, ms_min, ls_min}
//     inc_min   in  1   advance minutes by one (59 -> 00)
//     inc_hour  in  1   advance hours by one (23 -> 00)
//     min_carry in  1   let a 59 -> 00 minute wrap advance the hour
//     hhmm_next out 16  resulting hh:mm
//   The hour advances at most once per evaluation: inc_hour and a carried
//   minute wrap are OR-ed, never summed.
module al_timekeeper_bcd_hhmm_inc
  import al_timekeeper_pkg::*;
(
  input  logic [15:0] hhmm,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        min_carry,
  output logic [15:0] hhmm_next
);

  logic [3:0] ms_h, ls_h, ms_m, ls_m;
  logic [3:0] ms_h_n, ls_h_n, ms_m_n, ls_m_n;
  logic       min_wrap;
  logic       hour_step;

  assign {ms_h, ls_h, ms_m, ls_m} = hhmm;

  always_comb begin
    ms_h_n    = ms_h;
    ls_h_n    = ls_h;
    ms_m_n    = ms_m;
    ls_m_n    = ls_m;
    min_wrap  = 1'b0;
    hour_step = 1'b0;

    if (inc_min) begin
      if (ls_m == LS_DIGIT_MAX) begin
        ls_m_n = 4'd0;
        if (ms_m == MS_MIN_MAX) begin
          ms_m_n   = 4'd0;
          min_wrap = 1'b1;
        end else begin
          ms_m_n = ms_m + 4'd1;
        end
      end else begin
        ls_m_n = ls_m + 4'd1;
      end
    end

    hour_step = inc_hour | (min_wrap & min_carry);

    if (hour_step) begin
      if ((ms_h == MS_HOUR_MAX) && (ls_h == LS_HOUR_MAX_TOP)) begin
        ms_h_n = 4'd0;
        ls_h_n = 4'd0;
      end else if (ls_h == LS_DIGIT_MAX) begin
        ms_h_n = ms_h + 4'd1;
        ls_h_n = 4'd0;
      end else begin
        ls_h_n = ls_h + 4'd1;
      end
    end
  end

  assign hhmm_next = {ms_h_n, ls_h_n, ms_m_n, ls_m_n};

endmodule

// File: rtl/al_timekeeper.sv
// al_timekeeper
//   Single-clock time-of-day and alarm core. Time is kept internally as
//   24-hour BCD and advances on sec_tick enables; every output is a register
//   loaded from the same next-state values, so a sec_tick sampled at one
//   edge is visible on all outputs right after that edge.
//   Ports:
//     MCLK          in   system clock, rising edge
//     rst_n         in   synchronous reset, active low
//     sec_tick      in   one-cycle enable, one per second
//     fast_mode     in   each sec_tick advances one minute, seconds held 0
//     set_time      in   level: clock stopped, inc_* edit time
//     set_alarm     in   level: inc_* edit alarm (set_time has priority)
//     inc_hour      in   one-cycle pulse
//     inc_min       in   one-cycle pulse
//     alarm_en      in   level: alarm armed
//     snooze        in   one-cycle pulse
//     alarm_off     in   one-cycle pulse
//     time_bcd      out  16  display-mode hh:mm
//     alarm_bcd     out  16  alarm hh:mm, 24-hour BCD
//     seconds       out  6   binary seconds
//     pm            out  1   hour >= 12
//     minute_pulse  out  1   minute changed by rollover this cycle
//     alarm_active  out  1   alarm state is RINGING
//     dbg_state     out  2   alarm state machine state
//   All control inputs are plain levels or single-cycle pulses sampled on
//   the rising edge; there is no back-pressure on any input.
module al_timekeeper
  import al_timekeeper_pkg::*;
#(
  parameter bit          HOUR_24     = 1'b1,
  parameter int unsigned SEC_PER_MIN = 60,
  parameter int unsigned SNOOZE_MIN  = 9,
  parameter int unsigned RING_MIN    = 1,
  parameter logic [15:0] ALARM_RST   = 16'h0600
) (
  input  logic         MCLK,
  input  logic         rst_n,
  input  logic         sec_tick,
  input  logic         fast_mode,
  input  logic         set_time,
  input  logic         set_alarm,
  input  logic         inc_hour,
  input  logic         inc_min,
  input  logic         alarm_en,
  input  logic         snooze,
  input  logic         alarm_off,
  output logic [15:0]  time_bcd,
  output logic [15:0]  alarm_bcd,
  output logic [5:0]   seconds,
  output logic         pm,
  output logic         minute_pulse,
  output logic         alarm_active,
  output alarm_state_e dbg_state
);

  localparam logic [5:0] SEC_LAST    = 6'(SEC_PER_MIN - 1);
  localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LOAD   = 4'(RING_MIN);

  logic [15:0]  time_hm;
  logic [15:0]  time_n;
  logic [15:0]  alarm_n;
  logic [5:0]   sec_n;
  logic         adv_min;
  logic         edit_alarm;
  logic         trigger;
  logic         cnt_expire;
  logic [3:0]   cnt_q;
  alarm_state_e state_q;

  function automatic logic [15:0] to_display(input logic [15:0] hhmm);
    if (HOUR_24) return hhmm;
    else         return {hour_to_12(hhmm[15:8]), hhmm[7:0]};
  endfunction

  assign edit_alarm = set_alarm & ~set_time;

  // Seconds next value and the "a minute rolled over" enable.
  always_comb begin
    sec_n   = seconds;
    adv_min = 1'b0;
    if (set_time) begin
      if (inc_min || inc_hour) sec_n = 6'd0;
    end else if (fast_mode) begin
      sec_n   = 6'd0;
      adv_min = sec_tick;
    end else if (sec_tick) begin
      if (seconds >= SEC_LAST) begin
        sec_n   = 6'd0;
        adv_min = 1'b1;
      end else begin
        sec_n = seconds + 6'd1;
      end
    end
  end

  // Time: rollover minutes carry into hours; editing never carries.
  al_timekeeper_bcd_hhmm_inc u_time_inc (
    .hhmm      (time_hm),
    .inc_min   (set_time ? inc_min : adv_min),
    .inc_hour  (set_time & inc_hour),
    .min_carry (~set_time),
    .hhmm_next (time_n)
  );

  al_timekeeper_bcd_hhmm_inc u_alarm_inc (
    .hhmm      (alarm_bcd),
    .inc_min   (edit_alarm & inc_min),
    .inc_hour  (edit_alarm & inc_hour),
    .min_carry (1'b0),
    .hhmm_next (alarm_n)
  );

  // Only a rollover can trigger; set_time edits force adv_min low.
  assign trigger    = adv_min & alarm_en & (time_n == alarm_bcd);
  assign cnt_expire = adv_min & (cnt_q <= 4'd1);

  always_ff @(posedge MCLK) begin
    if (!rst_n) begin
      time_hm      <= 16'h0000;
      seconds      <= 6'd0;
      alarm_bcd    <= ALARM_RST;
      time_bcd     <= to_display(16'h0000);
      pm           <= 1'b0;
      minute_pulse <= 1'b0;
      alarm_active <= 1'b0;
      cnt_q        <= 4'd0;
      state_q      <= ST_IDLE;
    end else begin
      time_hm      <= time_n;
      seconds      <= sec_n;
      alarm_bcd    <= alarm_n;
      time_bcd     <= to_display(time_n);
      pm           <= hour_is_pm(time_n[15:8]);
      minute_pulse <= adv_min;

      if (!alarm_en || alarm_off) begin
        state_q      <= ST_IDLE;
        alarm_active <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trigger) begin
              state_q      <= ST_RINGING;
              cnt_q        <= RING_LOAD;
              alarm_active <= 1'b1;
            end
          end
          ST_RINGING: begin
            if (snooze) begin
              state_q      <= ST_SNOOZING;
              cnt_q        <= SNOOZE_LOAD;
              alarm_active <= 1'b0;
            end else if (trigger) begin
              cnt_q <= RING_LOAD;
            end else if (cnt_expire) begin
              state_q      <= ST_IDLE;
              cnt_q        <= 4'd0;
              alarm_active <= 1'b0;
            end else if (adv_min) begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_SNOOZING: begin
            if (trigger || cnt_expire) begin
              state_q      <= ST_RINGING;
              cnt_q        <= RING_LOAD;
              alarm_active <= 1'b1;
            end else if (adv_min) begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            alarm_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_al_timekeeper.sv
// Testbench for al_timekeeper. Two instances share all inputs: one in
// 24-hour mode (a_*) and one in 12-hour mode (b_*), both with four ticks
// per minute. A minute-of-day reference model tracks expected behaviour.
module tb_al_timekeeper;

  localparam int SPM = 4;
  localparam int SNZ = 9;
  localparam int RNG = 1;

  // ---------------- clock / reset ----------------
  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic rst_n = 1'b1;
  logic sec_tick = 0, fast_mode = 0, set_time = 0, set_alarm = 0;
  logic inc_hour = 0, inc_min = 0, alarm_en = 0, snooze = 0, alarm_off = 0;

  logic [15:0] a_time, a_alarm, b_time, b_alarm;
  logic [5:0]  a_sec, b_sec;
  logic        a_pm, b_pm, a_mp, b_mp, a_act, b_act;
  logic [1:0]  a_state, b_state;

  int errors = 0;
  int checks = 0;

  al_timekeeper #(.HOUR_24(1'b1), .SEC_PER_MIN(SPM), .SNOOZE_MIN(SNZ),
                  .RING_MIN(RNG), .ALARM_RST(16'h0600)) dut24 (
    .MCLK(MCLK), .rst_n(rst_n), .sec_tick(sec_tick), .fast_mode(fast_mode),
    .set_time(set_time), .set_alarm(set_alarm), .inc_hour(inc_hour),
    .inc_min(inc_min), .alarm_en(alarm_en), .snooze(snooze),
    .alarm_off(alarm_off), .time_bcd(a_time), .alarm_bcd(a_alarm),
    .seconds(a_sec), .pm(a_pm), .minute_pulse(a_mp),
    .alarm_active(a_act), .dbg_state(a_state));

  al_timekeeper #(.HOUR_24(1'b0), .SEC_PER_MIN(SPM), .SNOOZE_MIN(SNZ),
                  .RING_MIN(RNG), .ALARM_RST(16'h0600)) dut12 (
    .MCLK(MCLK), .rst_n(rst_n), .sec_tick(sec_tick), .fast_mode(fast_mode),
    .set_time(set_time), .set_alarm(set_alarm), .inc_hour(inc_hour),
    .inc_min(inc_min), .alarm_en(alarm_en), .snooze(snooze),
    .alarm_off(alarm_off), .time_bcd(b_time), .alarm_bcd(b_alarm),
    .seconds(b_sec), .pm(b_pm), .minute_pulse(b_mp),
    .alarm_active(b_act), .dbg_state(b_state));

  // ---------------- reference model ----------------
  // Time and alarm are minutes-of-day integers; state 0/1/2 = idle/ring/snooze.
  int m_t, m_sec, m_al, m_st, m_cnt;
  bit m_mp;
  int mh, mm, old_al;
  bit adv, trig;

  always @(posedge MCLK) begin
    if (!rst_n) begin
      m_t = 0; m_sec = 0; m_al = 6 * 60; m_st = 0; m_cnt = 0; m_mp = 0;
    end else begin
      adv = 0;
      old_al = m_al;
      if (set_time) begin
        mh = m_t / 60; mm = m_t % 60;
        if (inc_min)  mm = (mm + 1) % 60;
        if (inc_hour) mh = (mh + 1) % 24;
        m_t = mh * 60 + mm;
        if (inc_min || inc_hour) m_sec = 0;
      end else begin
        if (set_alarm) begin
          mh = m_al / 60; mm = m_al % 60;
          if (inc_min)  mm = (mm + 1) % 60;
          if (inc_hour) mh = (mh + 1) % 24;
          m_al = mh * 60 + mm;
        end
        if (fast_mode) begin
          m_sec = 0;
          adv = sec_tick;
        end else if (sec_tick) begin
          m_sec = m_sec + 1;
          if (m_sec == SPM) begin m_sec = 0; adv = 1; end
        end
        if (adv) m_t = (m_t + 1) % 1440;
      end
      m_mp = adv;
      trig = adv && alarm_en && (m_t == old_al);
      if (!alarm_en || alarm_off) begin
        m_st = 0;
      end else if (m_st == 1 && snooze) begin
        m_st = 2; m_cnt = SNZ;
      end else if (trig) begin
        m_st = 1; m_cnt = RNG;
      end else if (adv && m_st != 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          if (m_st == 1) m_st = 0;
          else begin m_st = 1; m_cnt = RNG; end
        end
      end
    end
  end

  function automatic logic [15:0] hm_bcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic int hour12(input int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge MCLK);
    #1;
    sec_tick = 0; inc_hour = 0; inc_min = 0; snooze = 0; alarm_off = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; cycle(); rst_n = 1;
  endtask

  task automatic press_hour(input int n);
    repeat (n) begin inc_hour = 1; cycle(); end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin inc_min = 1; cycle(); end
  endtask

  task automatic ticks(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      sec_tick = 1; cycle();
      if (a_mp === 1'b1) pulses++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    alarm_en = 1; sec_tick = 1; fast_mode = 0;
    do_reset();
    alarm_en = 0;
    checks++; if (a_time !== 16'h0000) begin errors++; $display("FAIL reset_time24 got %h exp 0000", a_time); end
    checks++; if (b_time !== 16'h1200) begin errors++; $display("FAIL reset_time12 got %h exp 1200", b_time); end
    checks++; if (a_sec !== 6'd0) begin errors++; $display("FAIL reset_sec got %0d exp 0", a_sec); end
    checks++; if (a_alarm !== 16'h0600) begin errors++; $display("FAIL reset_alarm got %h exp 0600", a_alarm); end
    checks++; if (a_act !== 1'b0 || a_mp !== 1'b0 || a_pm !== 1'b0 || b_pm !== 1'b0) begin
      errors++; $display("FAIL reset_flags got act=%b mp=%b pm=%b/%b exp 0", a_act, a_mp, a_pm, b_pm); end
  endtask

  task automatic test_rollover();
    int p;
    do_reset();
    set_time = 1; press_hour(23); press_min(59);
    checks++; if (a_time !== 16'h2359) begin errors++; $display("FAIL set_2359 got %h exp 2359", a_time); end
    press_min(1);
    checks++; if (a_time !== 16'h2300) begin errors++; $display("FAIL set_min_nocarry got %h exp 2300", a_time); end
    press_min(59); set_time = 0;
    ticks(SPM - 1, p);
    checks++; if (a_time !== 16'h2359 || a_sec !== 6'(SPM - 1)) begin
      errors++; $display("FAIL pre_roll got %h s=%0d exp 2359 s=%0d", a_time, a_sec, SPM - 1); end
    ticks(1, p);
    checks++; if (a_time !== 16'h0000 || a_sec !== 6'd0) begin
      errors++; $display("FAIL roll_day got %h s=%0d exp 0000 s=0", a_time, a_sec); end
    checks++; if (p !== 1) begin errors++; $display("FAIL roll_pulses got %0d exp 1", p); end
    cycle();
    checks++; if (a_mp !== 1'b0) begin errors++; $display("FAIL pulse_width got %b exp 0", a_mp); end
  endtask

  task automatic test_alarm_snooze();
    int p;
    do_reset();
    set_time = 1; press_hour(5); press_min(59); set_time = 0;
    alarm_en = 1;
    ticks(SPM - 1, p);
    checks++; if (a_act !== 1'b0) begin errors++; $display("FAIL alarm_early got %b exp 0", a_act); end
    ticks(1, p);
    checks++; if (a_act !== 1'b1 || a_time !== 16'h0600 || a_state !== 2'd1) begin
      errors++; $display("FAIL alarm_ring got act=%b t=%h st=%0d exp 1 0600 1", a_act, a_time, a_state); end
    snooze = 1; cycle();
    checks++; if (a_act !== 1'b0 || a_state !== 2'd2) begin
      errors++; $display("FAIL snooze got act=%b st=%0d exp 0 2", a_act, a_state); end
    ticks(SPM * (SNZ - 1), p);
    checks++; if (a_act !== 1'b0) begin errors++; $display("FAIL snooze_early got %b exp 0", a_act); end
    ticks(SPM, p);
    checks++; if (a_act !== 1'b1 || a_time !== 16'h0609) begin
      errors++; $display("FAIL snooze_ring got act=%b t=%h exp 1 0609", a_act, a_time); end
    alarm_off = 1; cycle();
    checks++; if (a_act !== 1'b0 || a_state !== 2'd0) begin
      errors++; $display("FAIL alarm_off got act=%b st=%0d exp 0 0", a_act, a_state); end
    set_alarm = 1; press_min(10); set_alarm = 0;
    checks++; if (a_alarm !== 16'h0610 || a_time !== 16'h0609) begin
      errors++; $display("FAIL set_alarm got al=%h t=%h exp 0610 0609", a_alarm, a_time); end
    ticks(SPM, p);
    checks++; if (a_act !== 1'b1) begin errors++; $display("FAIL ring2 got %b exp 1", a_act); end
    ticks(SPM - 1, p);
    checks++; if (a_act !== 1'b1) begin errors++; $display("FAIL ring2_hold got %b exp 1", a_act); end
    ticks(1, p);
    checks++; if (a_act !== 1'b0 || a_time !== 16'h0611) begin
      errors++; $display("FAIL auto_stop got act=%b t=%h exp 0 0611", a_act, a_time); end
    alarm_en = 0;
  endtask

  task automatic test_hour12();
    do_reset();
    set_time = 1; press_min(30);
    checks++; if (b_time !== 16'h1230 || b_pm !== 1'b0 || a_time !== 16'h0030) begin
      errors++; $display("FAIL h12_0030 got %h pm=%b a=%h exp 1230 0 0030", b_time, b_pm, a_time); end
    press_min(30); press_hour(12);
    checks++; if (b_time !== 16'h1200 || b_pm !== 1'b1 || a_pm !== 1'b1) begin
      errors++; $display("FAIL h12_1200 got %h pm=%b/%b exp 1200 1", b_time, b_pm, a_pm); end
    press_hour(1); press_min(5);
    checks++; if (b_time !== 16'h0105 || b_pm !== 1'b1 || a_time !== 16'h1305) begin
      errors++; $display("FAIL h12_1305 got %h pm=%b a=%h exp 0105 1 1305", b_time, b_pm, a_time); end
    press_hour(7);
    checks++; if (b_time !== 16'h0805 || b_pm !== 1'b1) begin
      errors++; $display("FAIL h12_2005 got %h pm=%b exp 0805 1", b_time, b_pm); end
    press_hour(3);
    checks++; if (b_time !== 16'h1105 || b_pm !== 1'b1) begin
      errors++; $display("FAIL h12_2305 got %h pm=%b exp 1105 1", b_time, b_pm); end
    set_time = 0;
  endtask

  task automatic test_set_priority();
    int p;
    do_reset();
    set_time = 1; press_hour(9); press_min(59); set_time = 0;
    ticks(2, p);
    set_time = 1;
    ticks(10, p);
    checks++; if (a_time !== 16'h0959 || a_sec !== 6'd2 || p !== 0) begin
      errors++; $display("FAIL set_hold got %h s=%0d mp=%0d exp 0959 2 0", a_time, a_sec, p); end
    set_alarm = 1; press_hour(1); set_alarm = 0;
    checks++; if (a_time !== 16'h1059 || a_alarm !== 16'h0600) begin
      errors++; $display("FAIL set_both got t=%h al=%h exp 1059 0600", a_time, a_alarm); end
    press_hour(23);
    inc_hour = 1; inc_min = 1; cycle();
    checks++; if (a_time !== 16'h1000 || a_sec !== 6'd0) begin
      errors++; $display("FAIL inc_both got %h s=%0d exp 1000 0", a_time, a_sec); end
    set_time = 0;
  endtask

  task automatic test_reset_ringing_fast();
    int p;
    do_reset();
    set_time = 1; press_hour(5); press_min(59); set_time = 0;
    alarm_en = 1; fast_mode = 1;
    ticks(1, p);
    checks++; if (a_act !== 1'b1 || a_time !== 16'h0600) begin
      errors++; $display("FAIL fast_ring got act=%b t=%h exp 1 0600", a_act, a_time); end
    rst_n = 0; cycle(); rst_n = 1;
    checks++; if (a_act !== 1'b0 || a_state !== 2'd0 || a_time !== 16'h0000) begin
      errors++; $display("FAIL reset_ring got act=%b st=%0d t=%h exp 0 0 0000", a_act, a_state, a_time); end
    alarm_en = 0;
    ticks(3, p);
    checks++; if (a_time !== 16'h0003 || a_sec !== 6'd0 || p !== 3) begin
      errors++; $display("FAIL fast_adv got %h s=%0d mp=%0d exp 0003 0 3", a_time, a_sec, p); end
    fast_mode = 0;
  endtask

  task automatic test_random();
    logic [15:0] e_a, e_b;
    int h;
    do_reset();
    alarm_en = 1;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 99) == 0)  fast_mode = ~fast_mode;
      if ($urandom_range(0, 79) == 0)  set_time  = ~set_time;
      if ($urandom_range(0, 79) == 0)  set_alarm = ~set_alarm;
      if ($urandom_range(0, 299) == 0) alarm_en  = ~alarm_en;
      if (set_time && $urandom_range(0, 3) == 0) set_time = 0;
      sec_tick  = 1'($urandom_range(0, 1));
      inc_min   = ($urandom_range(0, 5) == 0);
      inc_hour  = ($urandom_range(0, 7) == 0);
      snooze    = ($urandom_range(0, 29) == 0);
      alarm_off = ($urandom_range(0, 199) == 0);
      rst_n     = ($urandom_range(0, 999) != 0);
      cycle();
      rst_n = 1;
      h = m_t / 60;
      e_a = hm_bcd(h, m_t % 60);
      e_b = hm_bcd(hour12(h), m_t % 60);
      checks++; if (a_time !== e_a) begin errors++; $display("FAIL rnd_time24 cyc %0d got %h exp %h", i, a_time, e_a); end
      checks++; if (b_time !== e_b) begin errors++; $display("FAIL rnd_time12 cyc %0d got %h exp %h", i, b_time, e_b); end
      checks++; if (a_pm !== (h >= 12) || b_pm !== (h >= 12)) begin
        errors++; $display("FAIL rnd_pm cyc %0d got %b/%b exp %b", i, a_pm, b_pm, h >= 12); end
      checks++; if (a_sec !== 6'(m_sec) || b_sec !== 6'(m_sec)) begin
        errors++; $display("FAIL rnd_sec cyc %0d got %0d exp %0d", i, a_sec, m_sec); end
      checks++; if (a_alarm !== hm_bcd(m_al / 60, m_al % 60)) begin
        errors++; $display("FAIL rnd_alarm cyc %0d got %h exp %h", i, a_alarm, hm_bcd(m_al / 60, m_al % 60)); end
      checks++; if (a_mp !== m_mp || b_mp !== m_mp) begin
        errors++; $display("FAIL rnd_mp cyc %0d got %b exp %b", i, a_mp, m_mp); end
      checks++; if (a_act !== (m_st == 1) || b_act !== (m_st == 1)) begin
        errors++; $display("FAIL rnd_active cyc %0d got %b exp %b", i, a_act, m_st == 1); end
      checks++; if (a_state !== 2'(m_st)) begin
        errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", i, a_state, m_st); end
    end
    set_time = 0; set_alarm = 0; fast_mode = 0; alarm_en = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_rollover();
    test_alarm_snooze();
    test_hour12();
    test_set_priority();
    test_reset_ringing_fast();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
